mcm_fir4_accum: RTL and testbench

//  Downstream stage of the DSP48E1 constant-multiplier block (X*11, X*9, 1-clk latency, free-running PREG).

---
 rtl/mcm_pkg.sv | 15 +
 rtl/mcm_sync_fifo.sv | 85 ++++++++
 rtl/mcm_fir4_accum.sv | 124 ++++++++++++
 tb/tb_mcm_fir4_accum.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcm_pkg.sv
// Shared constants and types for the constant-multiplier FIR slice.
package mcm_pkg;

  localparam int MCM_PW     = 12;
  localparam int MCM_LAT    = 1;
  localparam int FIR4_OUT_W = 14;

  // Filter coefficients: outer taps use C0, inner taps use C1.
  localparam int C0 = 9;
  localparam int C1 = 11;

  typedef logic signed [MCM_PW-1:0]     prod_t;
  typedef logic signed [FIR4_OUT_W-1:0] acc_t;

endpackage

// File: rtl/mcm_sync_fifo.sv
// Single-clock FIFO with a registered head word; the head reads 0 when empty.
module mcm_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_n;
  logic             pop_eff;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next read pointer, occupancy and head word; a push lands directly in the
  // head when it becomes the oldest entry.
  always_comb begin
    pop_eff  = pop && (count_q != '0);
    rd_ptr_n = pop_eff ? ptr_inc(rd_ptr) : rd_ptr;
    count_n  = count_q;
    if (push && !pop_eff) begin
      count_n = count_q + 1'b1;
    end else if (!push && pop_eff) begin
      count_n = count_q - 1'b1;
    end
    head_n = '0;
    if (count_n != '0) begin
      if (push && (wr_ptr == rd_ptr_n)) begin
        head_n = din;
      end else begin
        head_n = mem[rd_ptr_n];
      end
    end
  end

  // Control state and the registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      rd_ptr  <= rd_ptr_n;
      count_q <= count_n;
      head_q  <= head_n;
    end
  end

  // Storage array carries no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout  = head_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mcm_fir4_accum.sv
// Adder/register half of a symmetric 4-tap transposed FIR fed by a
// free-running constant multiplier (11*X, 9*X); buffers results in a FIFO.
module mcm_fir4_accum #(
  parameter int PW         = mcm_pkg::MCM_PW,
  parameter int OUT_W      = mcm_pkg::FIR4_OUT_W,
  parameter int MCM_LAT    = mcm_pkg::MCM_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [PW-1:0]    x_11,
  input  logic signed [PW-1:0]    x_9,
  input  logic                    clear,
  output logic signed [OUT_W-1:0] y,
  output logic                    y_valid,
  input  logic                    y_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MCM_LAT + 1);
  localparam int OW = $clog2(FIFO_DEPTH + MCM_LAT + 1);

  logic [MCM_LAT-1:0]      vld_p;
  logic                    accept;
  logic                    pv;
  logic [IW-1:0]           inflight;
  logic [OW-1:0]           occupancy;
  logic signed [OUT_W-1:0] z1;
  logic signed [OUT_W-1:0] z2;
  logic signed [OUT_W-1:0] z3;
  logic signed [OUT_W-1:0] z1_h;
  logic signed [OUT_W-1:0] z2_h;
  logic signed [OUT_W-1:0] z3_h;
  logic signed [OUT_W-1:0] x11_e;
  logic signed [OUT_W-1:0] x9_e;
  logic signed [OUT_W-1:0] y_new;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [OUT_W-1:0]        fifo_dout;

  // Exact widening of a product; OUT_W leaves headroom so no saturation.
  function automatic logic signed [OUT_W-1:0] sext(input logic signed [PW-1:0] p);
    return OUT_W'(p);
  endfunction

  assign accept = in_valid && in_ready;
  assign pv     = vld_p[MCM_LAT-1];

  // Count samples still inside the multiplier and reserve FIFO room for them,
  // so the never-stalled multiplier can always deposit its result.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MCM_LAT; i++) begin
      inflight = inflight + IW'(vld_p[i]);
    end
    occupancy = OW'(fifo_count) + OW'(inflight);
    in_ready  = (occupancy < OW'(FIFO_DEPTH));
  end

  // ---- stage p0 -> product: valid shadow of the multiplier latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < MCM_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Tap history as seen this cycle; clear substitutes zero history.
  always_comb begin
    x11_e = sext(x_11);
    x9_e  = sext(x_9);
    z1_h  = clear ? '0 : z1;
    z2_h  = clear ? '0 : z2;
    z3_h  = clear ? '0 : z3;
    y_new = x9_e + z1_h;
  end

  // ---- product -> tap registers: history advances only on real samples
  always_ff @(posedge clk) begin
    if (rst) begin
      z1 <= '0;
      z2 <= '0;
      z3 <= '0;
    end else if (pv) begin
      z1 <= x11_e + z2_h;
      z2 <= x11_e + z3_h;
      z3 <= x9_e;
    end else if (clear) begin
      z1 <= '0;
      z2 <= '0;
      z3 <= '0;
    end
  end

  // ---- product -> output FIFO
  mcm_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pv),
    .din   (y_new),
    .pop   (y_ready),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign y       = fifo_dout;
  assign y_valid = !fifo_empty;

  // The in_ready reservation guarantees a free slot for every product.
  assert property (@(posedge clk) disable iff (rst) !(pv && fifo_full && !y_ready));

endmodule

// File: tb/tb_mcm_fir4_accum.sv
// Directed bench for mcm_fir4_accum with a behavioural constant multiplier.
module tb_mcm_fir4_accum;
  import mcm_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  logic  in_ready;
  logic  clear;
  logic  y_valid;
  logic  y_ready;
  prod_t x_11;
  prod_t x_9;
  acc_t  y;

  int x;
  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int got[$];

  typedef struct {
    int x;
    int gap;
    int exp_y;
  } vec_t;
  vec_t tbl[18];

  int bp_x[10];
  int clr_exp[6];

  mcm_fir4_accum #(
    .PW         (MCM_PW),
    .OUT_W      (FIR4_OUT_W),
    .MCM_LAT    (MCM_LAT),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_11     (x_11),
    .x_9      (x_9),
    .clear    (clear),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready)
  );

  always #5 clk = ~clk;

  // Free-running one-cycle constant multiplier.
  always @(posedge clk) begin
    x_11 <= prod_t'(C1 * x);
    x_9  <= prod_t'(C0 * x);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Record handshakes just before the edge, then move to 1 time unit after it.
  task automatic tick();
    if (y_valid && y_ready) got.push_back(int'(y));
    if (in_valid && in_ready) n_acc++;
    @(posedge clk);
    #1;
  endtask

  function automatic int fir_ref(input int k);
    int s;
    s = C0 * bp_x[k];
    if (k >= 1) s += C1 * bp_x[k-1];
    if (k >= 2) s += C1 * bp_x[k-2];
    if (k >= 3) s += C0 * bp_x[k-3];
    return s;
  endfunction

  task automatic run_group(input int lo, input int hi, input string tag);
    int n;
    int guard;
    int a0;
    n        = hi - lo + 1;
    y_ready  = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    got.delete();
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b0;
      repeat (tbl[i].gap) tick();
      x        = tbl[i].x;
      in_valid = 1'b1;
      a0       = n_acc;
      guard    = 0;
      while (n_acc == a0 && guard < 20) begin
        tick();
        guard++;
      end
    end
    in_valid = 1'b0;
    x        = 0;
    guard    = 0;
    while (got.size() < n && guard < 40) begin
      tick();
      guard++;
    end
    chk({tag, "_count"}, got.size(), n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : -99999, tbl[lo+k].exp_y);
    end
  endtask

  initial begin
    int base;
    int guard;
    logic [7:0] rdy_mask;

    tbl[0]  = '{1, 0, 9};
    tbl[1]  = '{0, 0, 11};
    tbl[2]  = '{0, 0, 11};
    tbl[3]  = '{0, 0, 9};
    tbl[4]  = '{0, 0, 0};
    tbl[5]  = '{0, 0, 0};
    tbl[6]  = '{0, 0, 0};
    tbl[7]  = '{0, 0, 0};
    tbl[8]  = '{-128, 0, -1152};
    tbl[9]  = '{-128, 0, -2560};
    tbl[10] = '{-128, 0, -3968};
    tbl[11] = '{-128, 0, -5120};
    tbl[12] = '{-128, 0, -5120};
    tbl[13] = '{-128, 0, -5120};
    tbl[14] = '{2, 0, 18};
    tbl[15] = '{0, 2, 22};
    tbl[16] = '{0, 1, 22};
    tbl[17] = '{3, 3, 45};
    bp_x    = '{1, 2, 3, 4, 5, -6, 7, -8, 9, 10};
    clr_exp = '{45, 100, 155, 45, 100, 155};

    rst      = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    y_ready  = 1'b0;
    x        = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // First-output latency of a single impulse sample.
    x        = 1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x        = 0;
    chk("lat_t1_y_valid", int'(y_valid), 0);
    tick();
    chk("lat_t2_y_valid", int'(y_valid), 1);
    chk("lat_t2_y", int'(y), 9);
    y_ready = 1'b1;
    repeat (6) tick();

    run_group(0, 7, "impulse");
    run_group(8, 13, "step_min");
    run_group(14, 17, "bubbles");

    // Backpressure: consumer stalled for 8 cycles with continuous input.
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    got.delete();
    y_ready  = 1'b0;
    base     = n_acc;
    rdy_mask = '0;
    for (int i = 0; i < 8; i++) begin
      x           = bp_x[n_acc - base];
      in_valid    = 1'b1;
      rdy_mask[i] = in_ready;
      tick();
    end
    chk("bp_accepted", n_acc - base, 4);
    chk("bp_ready_mask", int'(rdy_mask), 8'h0F);
    chk("bp_in_ready_low", int'(in_ready), 0);
    chk("bp_no_pops", got.size(), 0);
    y_ready = 1'b1;
    guard   = 0;
    while ((n_acc - base) < 10 && guard < 40) begin
      x        = bp_x[n_acc - base];
      in_valid = 1'b1;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    guard    = 0;
    while (got.size() < 10 && guard < 40) begin
      tick();
      guard++;
    end
    chk("bp_count", got.size(), 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp[%0d]", k), (k < got.size()) ? got[k] : -99999, fir_ref(k));
    end

    // clear coincident with the arrival of the 4th product, FIFO stalled.
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    got.delete();
    y_ready  = 1'b0;
    base     = n_acc;
    x        = 5;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_accepted", n_acc - base, 4);
    y_ready  = 1'b1;
    in_valid = 1'b1;
    guard    = 0;
    while ((n_acc - base) < 6 && guard < 20) begin
      tick();
      guard++;
    end
    in_valid = 1'b0;
    guard    = 0;
    while (got.size() < 6 && guard < 40) begin
      tick();
      guard++;
    end
    chk("clr_count", got.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("clr[%0d]", k), (k < got.size()) ? got[k] : -99999, clr_exp[k]);
    end

    // Reset with three entries queued, then a clean impulse.
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    y_ready  = 1'b0;
    x        = 7;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    x        = 0;
    tick();
    chk("pre_rst_y_valid", int'(y_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_y_valid", int'(y_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_y", int'(y), 0);
    run_group(0, 7, "impulse_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
